sprite_mover: RTL and testbench



---
 rtl/game_pkg.sv | 40 ++++
 rtl/move_tick_gen.sv | 32 +++
 rtl/sprite_mover.sv | 160 ++++++++++++++++
 tb/tb_sprite_mover.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - direction encoding, key mapping and width helper shared by actor logic
package game_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    // dir_held / blocked bit positions deliberately match the facing encoding
    localparam int BIT_UP    = 0;
    localparam int BIT_RIGHT = 1;
    localparam int BIT_LEFT  = 2;
    localparam int BIT_DOWN  = 3;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    function automatic logic [3:0] key_to_held(input logic [7:0] code);
        logic [3:0] r_held;
        r_held = 4'b0000;
        case (code)
            KEY_UP:    r_held[BIT_UP]    = 1'b1;
            KEY_RIGHT: r_held[BIT_RIGHT] = 1'b1;
            KEY_LEFT:  r_held[BIT_LEFT]  = 1'b1;
            KEY_DOWN:  r_held[BIT_DOWN]  = 1'b1;
            default:   r_held = 4'b0000;
        endcase
        return r_held;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/move_tick_gen.sv
// rtl/move_tick_gen.sv - free-running move tick divider with synchronous clear
module move_tick_gen
    import game_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CNTW = clog2(TICK_DIV);

    logic [CNTW-1:0] r_cnt;
    logic            w_last;

    assign w_last = (r_cnt == CNTW'(TICK_DIV - 1));
    assign o_tick = i_en && !i_clr && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - clamped, rate-limited sprite motion and walk-cycle animation
module sprite_mover
    import game_pkg::*;
#(
    parameter int CW       = 9,
    parameter int FRAMES   = 3,
    parameter int STEP     = 2,
    parameter int TICK_DIV = 1_000_000,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 319,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 239
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          load,
    input  logic [CW-1:0]                 load_x,
    input  logic [CW-1:0]                 load_y,
    input  logic [3:0]                    dir_held,
    input  logic [3:0]                    blocked,
    output logic [CW-1:0]                 pos_x,
    output logic [CW-1:0]                 pos_y,
    output logic [1:0]                    facing,
    output logic [clog2(FRAMES)-1:0]      frame,
    output logic [clog2(4*FRAMES)-1:0]    sprite_state,
    output logic                          moving,
    output logic                          step_pulse
);

    localparam int FW  = clog2(FRAMES);
    localparam int SW  = clog2(4 * FRAMES);
    localparam int CWE = CW + 1;

    localparam logic [CWE-1:0] XMIN_E = CWE'(X_MIN);
    localparam logic [CWE-1:0] XMAX_E = CWE'(X_MAX);
    localparam logic [CWE-1:0] YMIN_E = CWE'(Y_MIN);
    localparam logic [CWE-1:0] YMAX_E = CWE'(Y_MAX);
    localparam logic [CWE-1:0] STEP_E = CWE'(STEP);
    localparam logic [FW-1:0]  LAST_FRAME = FW'(FRAMES - 1);

    logic [CW-1:0] r_pos_x, r_pos_y;
    logic [1:0]    r_facing;
    logic [FW-1:0] r_frame;
    logic [SW-1:0] r_sprite;
    logic          r_moving, r_step;

    logic [CW-1:0] w_nxt_x, w_nxt_y;
    logic [1:0]    w_nxt_facing, w_sel_dir;
    logic [FW-1:0] w_nxt_frame, w_adv_frame;
    logic [SW-1:0] w_nxt_sprite;
    logic          w_nxt_moving, w_nxt_step, w_has_dir, w_sel_blocked, w_tick;

    // Arithmetic is one bit wider than the coordinate so neither edge can wrap.
    function automatic logic [CW-1:0] inc_clamp(input logic [CW-1:0] p, input logic [CWE-1:0] hi);
        logic [CWE-1:0] s;
        s = {1'b0, p} + STEP_E;
        return (s > hi) ? hi[CW-1:0] : s[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] dec_clamp(input logic [CW-1:0] p, input logic [CWE-1:0] lo);
        logic [CWE-1:0] d;
        d = {1'b0, p} - STEP_E;
        return ({1'b0, p} < lo + STEP_E) ? lo[CW-1:0] : d[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] lim(input logic [CW-1:0] p, input logic [CWE-1:0] lo,
                                          input logic [CWE-1:0] hi);
        if ({1'b0, p} < lo) return lo[CW-1:0];
        if ({1'b0, p} > hi) return hi[CW-1:0];
        return p;
    endfunction

    move_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (en),
        .i_clr  (load),
        .o_tick (w_tick)
    );

    assign w_adv_frame = (r_frame == LAST_FRAME || r_frame == '0) ? FW'(1) : r_frame + 1'b1;

    always_comb begin
        w_has_dir = |dir_held;
        if (dir_held[BIT_UP])        w_sel_dir = DIR_UP;
        else if (dir_held[BIT_LEFT]) w_sel_dir = DIR_LEFT;
        else if (dir_held[BIT_DOWN]) w_sel_dir = DIR_DOWN;
        else                         w_sel_dir = DIR_RIGHT;
        w_sel_blocked = blocked[w_sel_dir];

        w_nxt_x      = r_pos_x;
        w_nxt_y      = r_pos_y;
        w_nxt_facing = r_facing;
        w_nxt_frame  = r_frame;
        w_nxt_moving = r_moving;
        w_nxt_step   = 1'b0;

        if (load) begin
            w_nxt_x      = lim(load_x, XMIN_E, XMAX_E);
            w_nxt_y      = lim(load_y, YMIN_E, YMAX_E);
            w_nxt_facing = DIR_RIGHT;
            w_nxt_frame  = '0;
            w_nxt_moving = 1'b0;
        end else if (!en || !w_has_dir) begin
            w_nxt_frame  = '0;
            w_nxt_moving = 1'b0;
        end else begin
            w_nxt_facing = w_sel_dir;
            if (w_tick) begin
                if (w_sel_blocked) begin
                    w_nxt_frame  = '0;
                    w_nxt_moving = 1'b0;
                end else begin
                    w_nxt_frame  = w_adv_frame;
                    w_nxt_moving = 1'b1;
                    w_nxt_step   = 1'b1;
                    case (w_sel_dir)
                        DIR_UP:    w_nxt_y = dec_clamp(r_pos_y, YMIN_E);
                        DIR_DOWN:  w_nxt_y = inc_clamp(r_pos_y, YMAX_E);
                        DIR_LEFT:  w_nxt_x = dec_clamp(r_pos_x, XMIN_E);
                        default:   w_nxt_x = inc_clamp(r_pos_x, XMAX_E);
                    endcase
                end
            end
        end
        w_nxt_sprite = SW'(w_nxt_facing) * SW'(FRAMES) + SW'(w_nxt_frame);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos_x  <= XMIN_E[CW-1:0];
            r_pos_y  <= YMIN_E[CW-1:0];
            r_facing <= DIR_RIGHT;
            r_frame  <= '0;
            r_sprite <= SW'(FRAMES);
            r_moving <= 1'b0;
            r_step   <= 1'b0;
        end else begin
            r_pos_x  <= w_nxt_x;
            r_pos_y  <= w_nxt_y;
            r_facing <= w_nxt_facing;
            r_frame  <= w_nxt_frame;
            r_sprite <= w_nxt_sprite;
            r_moving <= w_nxt_moving;
            r_step   <= w_nxt_step;
        end
    end

    assign pos_x        = r_pos_x;
    assign pos_y        = r_pos_y;
    assign facing       = r_facing;
    assign frame        = r_frame;
    assign sprite_state = r_sprite;
    assign moving       = r_moving;
    assign step_pulse   = r_step;

endmodule

// File: tb/tb_sprite_mover.sv
// tb/tb_sprite_mover.sv - directed self-checking bench for sprite_mover
module tb_sprite_mover;

    logic       clk = 1'b0;
    logic       rst_n, en, load;
    logic [8:0] load_x, load_y, pos_x, pos_y;
    logic [3:0] dir_held, blocked;
    logic [1:0] facing, frame;
    logic [3:0] sprite_state;
    logic       moving, step_pulse;

    int checks   = 0;
    int failures = 0;
    int pulses;

    sprite_mover #(
        .CW(9), .FRAMES(3), .STEP(2), .TICK_DIV(4),
        .X_MIN(0), .X_MAX(319), .Y_MIN(0), .Y_MAX(239)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .load_x(load_x), .load_y(load_y), .dir_held(dir_held), .blocked(blocked),
        .pos_x(pos_x), .pos_y(pos_y), .facing(facing), .frame(frame),
        .sprite_state(sprite_state), .moving(moving), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input int x, input int y, input logic [3:0] dirs);
        load_x = 9'(x); load_y = 9'(y); dir_held = dirs; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; load = 1'b0; load_x = '0; load_y = '0;
        dir_held = '0; blocked = '0;
        #12;
        chk("rst_pos_x", pos_x, 0);
        chk("rst_pos_y", pos_y, 0);
        chk("rst_facing", facing, 1);
        chk("rst_frame", frame, 0);
        chk("rst_sprite", sprite_state, 3);
        chk("rst_moving", moving, 0);
        chk("rst_step", step_pulse, 0);
        rst_n = 1'b1;

        // Walk right from (100,50): moves on every 4th edge after the load edge
        do_load(100, 50, 4'b0000);
        chk("load_x", pos_x, 100);
        chk("load_y", pos_y, 50);
        dir_held = 4'b0010;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (step_pulse === 1'b1) pulses++;
            chk("walk_pulse", step_pulse, (i % 4 == 3) ? 1 : 0);
            if (i % 4 == 3) begin
                chk("walk_x", pos_x, 102 + 2 * (i / 4));
                chk("walk_frame", frame, (i / 4 == 1) ? 2 : 1);
                chk("walk_sprite", sprite_state, (i / 4 == 1) ? 5 : 4);
            end
        end
        chk("walk_pulses", pulses, 3);

        // Right edge clamp, then left edge clamp
        do_load(318, 0, 4'b0010);
        chk("edge_load_x", pos_x, 318);
        repeat (4) step();
        chk("right_clamp1", pos_x, 319);
        repeat (4) step();
        chk("right_clamp2", pos_x, 319);
        do_load(1, 0, 4'b0100);
        repeat (4) step();
        chk("left_clamp1", pos_x, 0);
        chk("left_facing", facing, 2);
        repeat (4) step();
        chk("left_clamp2", pos_x, 0);

        do_load(400, 300, 4'b0000);
        chk("load_clamp_x", pos_x, 319);
        chk("load_clamp_y", pos_y, 239);

        // UP beats RIGHT; then blocked UP holds position
        do_load(100, 50, 4'b0011);
        step();
        chk("prio_facing", facing, 0);
        repeat (3) step();
        chk("up_y", pos_y, 48);
        chk("up_x", pos_x, 100);
        chk("up_moving", moving, 1);
        dir_held = 4'b0001; blocked = 4'b0001;
        repeat (4) step();
        chk("blk_y", pos_y, 48);
        chk("blk_frame", frame, 0);
        chk("blk_moving", moving, 0);
        chk("blk_facing", facing, 0);
        chk("blk_step", step_pulse, 0);

        // Release keys at frame 2
        blocked = 4'b0000;
        repeat (4) step();
        chk("rel_y1", pos_y, 46);
        chk("rel_frame1", frame, 1);
        repeat (4) step();
        chk("rel_y2", pos_y, 44);
        chk("rel_frame2", frame, 2);
        chk("rel_sprite2", sprite_state, 2);
        dir_held = 4'b0000;
        step();
        chk("rel_frame0", frame, 0);
        chk("rel_moving", moving, 0);
        chk("rel_sprite0", sprite_state, 0);

        // Drop enable during a downward walk
        do_load(50, 60, 4'b1000);
        repeat (4) step();
        chk("down_y", pos_y, 62);
        chk("down_facing", facing, 3);
        chk("down_sprite", sprite_state, 10);
        repeat (2) step();
        en = 1'b0;
        step();
        chk("dis_frame", frame, 0);
        chk("dis_moving", moving, 0);
        pulses = 0;
        repeat (5) begin
            step();
            if (step_pulse === 1'b1) pulses++;
        end
        chk("dis_pulses", pulses, 0);
        chk("dis_y", pos_y, 62);
        en = 1'b1;
        repeat (3) step();
        chk("ren_wait_y", pos_y, 62);
        step();
        chk("ren_y", pos_y, 64);
        chk("ren_pulse", step_pulse, 1);
        chk("ren_frame", frame, 1);

        // Asynchronous reset between edges
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_x", pos_x, 0);
        chk("arst_y", pos_y, 0);
        chk("arst_sprite", sprite_state, 3);
        chk("arst_facing", facing, 1);
        chk("arst_moving", moving, 0);
        rst_n = 1'b1;
        step();
        chk("resume_facing", facing, 3);
        repeat (2) step();
        chk("resume_wait_y", pos_y, 0);
        step();
        chk("resume_y", pos_y, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
